// File: rtl/exe_result_fifo_if.sv
// Handshake bundle between the execution-result FIFO and its producer/consumer.
// slave = FIFO side, master = environment (execution unit + consumer) side.
interface exe_result_fifo_if #(
  parameter int unsigned ARG_BYTES = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 i_valid;
  logic [ARG_BYTES-1:0] i_result;
  logic [3:0]           i_status;
  logic                 i_ready;
  logic                 o_ready;
  logic                 o_valid;
  logic [ARG_BYTES-1:0] o_result;
  logic [3:0]           o_status;
  logic [CNT_W-1:0]     o_count;
  logic                 o_overflow;
  logic [ERR_CNT_W-1:0] o_err_cnt;

  modport slave (
    input  i_valid, i_result, i_status, i_ready,
    output o_ready, o_valid, o_result, o_status, o_count, o_overflow, o_err_cnt
  );

  modport master (
    output i_valid, i_result, i_status, i_ready,
    input  o_ready, o_valid, o_result, o_status, o_count, o_overflow, o_err_cnt
  );
endinterface

// File: rtl/exe_result_fifo.sv
// Result/status buffer behind the execution unit: never stalls input, drops on full.
// Optional same-cycle forwarding into an empty buffer under `EXE_RES_BYPASS_EN.
module exe_result_fifo #(
  parameter int unsigned ARG_BYTES = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                i_clk,
  input logic                i_rsn,
  exe_result_fifo_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = ARG_BYTES + 4;

  typedef logic [ENT_W-1:0] entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  entry_t in_ent;
  entry_t out_ent;
  logic   valid_c;
  logic   not_full;
  logic   pop;
  logic   push_ok;
  logic   wr_en;
  logic   rd_en;

  // Head selection, handshake decode and next-state computation.
  always_comb begin
    in_ent     = {bus.i_status, bus.i_result};
    out_ent    = mem_q[rd_ptr_q];
    valid_c    = (count_q != '0);
    not_full   = (count_q < CNT_W'(DEPTH));
`ifdef EXE_RES_BYPASS_EN
    if ((count_q == '0) && bus.i_valid) begin
      valid_c = 1'b1;
      out_ent = in_ent;
    end
`endif
    pop        = valid_c & bus.i_ready;
    push_ok    = bus.i_valid & (not_full | pop);
    wr_en      = push_ok;
    rd_en      = pop;
`ifdef EXE_RES_BYPASS_EN
    // A forwarded entry taken the same cycle never touches storage.
    if ((count_q == '0) && bus.i_valid && bus.i_ready) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
`endif

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.i_valid & ~push_ok);
    err_cnt_d  = err_cnt_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = in_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push_ok && bus.i_status[3] && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Control state; storage contents are left unreset.
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_valid    = valid_c;
  assign bus.o_result   = valid_c ? out_ent[ARG_BYTES-1:0] : '0;
  assign bus.o_status   = valid_c ? out_ent[ENT_W-1:ARG_BYTES] : 4'b0;
  assign bus.o_ready    = not_full;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_exe_result_fifo.sv
// Scoreboard bench for exe_result_fifo; expected entries queued at drive time,
// compared whenever the consumer handshake completes.
module tb_exe_result_fifo;
  localparam int unsigned ARG_BYTES = 4;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned ERR_CNT_W = 8;

  logic i_clk;
  logic i_rsn;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_q[$];

  exe_result_fifo_if #(.ARG_BYTES(ARG_BYTES), .DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  exe_result_fifo #(.ARG_BYTES(ARG_BYTES), .DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .i_clk (i_clk),
    .i_rsn (i_rsn),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle of stimulus; exp_push queues the entry the bench expects to emerge.
  task automatic drive(input logic v, input logic [3:0] st, input logic [3:0] res,
                       input logic rdy, input logic exp_push);
    bus.i_valid  = v;
    bus.i_status = st;
    bus.i_result = res;
    bus.i_ready  = rdy;
    if (exp_push) exp_q.push_back({st, res});
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rsn = 1'b1;
    exp_q.delete();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    i_rsn = 1'b0;
  endtask

  // Consumer-side scoreboard, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rsn && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_pop", 32'(bus.o_valid), 32'd0);
      end else begin
        check_eq("sb_data", 32'({bus.o_status, bus.o_result}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    i_rsn = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_status = 4'h0;
    bus.i_result = 4'h0;
    bus.i_ready  = 1'b0;

    // Reset then idle
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    i_rsn = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq("rst_valid",    32'(bus.o_valid),    32'd0);
    check_eq("rst_result",   32'(bus.o_result),   32'd0);
    check_eq("rst_status",   32'(bus.o_status),   32'd0);
    check_eq("rst_count",    32'(bus.o_count),    32'd0);
    check_eq("rst_ready",    32'(bus.o_ready),    32'd1);
    check_eq("rst_overflow", 32'(bus.o_overflow), 32'd0);
    check_eq("rst_err_cnt",  32'(bus.o_err_cnt),  32'd0);

    // Order and latency
`ifndef EXE_RES_BYPASS_EN
    bus.i_valid  = 1'b1;
    bus.i_result = 4'h1;
    #1;
    check_eq("lat_no_comb_path", 32'(bus.o_valid), 32'd0);
`endif
    drive(1'b1, 4'h0, 4'h1, 1'b0, 1'b1);
    check_eq("lat_valid_next", 32'(bus.o_valid), 32'd1);
    drive(1'b1, 4'h0, 4'h2, 1'b0, 1'b1);
    drive(1'b1, 4'h0, 4'h3, 1'b0, 1'b1);
    check_eq("order_count3", 32'(bus.o_count), 32'd3);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    check_eq("order_valid_low", 32'(bus.o_valid), 32'd0);
    check_eq("order_count0",    32'(bus.o_count), 32'd0);

    // Full and drop
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'h0, 4'(i), 1'b0, i < 8);
      if (i == 7) check_eq("full_ready_low", 32'(bus.o_ready), 32'd0);
    end
    check_eq("drop_overflow", 32'(bus.o_overflow), 32'd1);
    check_eq("drop_count8",   32'(bus.o_count),    32'd8);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    check_eq("drop_drained", 32'(bus.o_count), 32'd0);
    check_eq("drop_overflow_sticky", 32'(bus.o_overflow), 32'd1);

    // Full with simultaneous pop
    do_reset();
    check_eq("rst2_overflow", 32'(bus.o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h0, 4'(i + 1), 1'b0, 1'b1);
    drive(1'b1, 4'h0, 4'hA, 1'b1, 1'b1);
    check_eq("fullpop_count8",   32'(bus.o_count),    32'd8);
    check_eq("fullpop_overflow", 32'(bus.o_overflow), 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    check_eq("fullpop_drained", 32'(bus.o_count), 32'd0);

    // Wrap and error count
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, ((k % 4) == 3) ? 4'b1000 : 4'(k % 2) * 4'b0101, 4'(k),
            (k % 3) != 0, 1'b1);
    end
    check_eq("wrap_err_cnt", 32'(bus.o_err_cnt), 32'd5);
    check_eq("wrap_count",   32'(bus.o_count),   32'd7);
    for (int i = 0; i < 7; i++) drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    check_eq("wrap_drained", 32'(bus.o_valid), 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b1000, 4'(i + 3), 1'b0, 1'b1);
    check_eq("mid_err_cnt", 32'(bus.o_err_cnt), 32'd10);
    i_rsn = 1'b1;
    exp_q.delete();
    drive(1'b1, 4'b1000, 4'h5, 1'b1, 1'b0);
    i_rsn = 1'b0;
    check_eq("mid_count",   32'(bus.o_count),   32'd0);
    check_eq("mid_valid",   32'(bus.o_valid),   32'd0);
    check_eq("mid_err_rst", 32'(bus.o_err_cnt), 32'd0);

    // Empty buffer, push with consumer ready
    bus.i_valid  = 1'b1;
    bus.i_status = 4'h0;
    bus.i_result = 4'h7;
    bus.i_ready  = 1'b1;
    #1;
`ifdef EXE_RES_BYPASS_EN
    check_eq("byp_valid",  32'(bus.o_valid),  32'd1);
    check_eq("byp_result", 32'(bus.o_result), 32'd7);
    check_eq("byp_count",  32'(bus.o_count),  32'd0);
    drive(1'b1, 4'h0, 4'h7, 1'b1, 1'b1);
    check_eq("byp_count_after", 32'(bus.o_count), 32'd0);
    check_eq("byp_valid_after", 32'(bus.o_valid), 32'd0);
`else
    check_eq("nobyp_valid",  32'(bus.o_valid),  32'd0);
    check_eq("nobyp_result", 32'(bus.o_result), 32'd0);
    drive(1'b1, 4'h0, 4'h7, 1'b1, 1'b1);
    check_eq("nobyp_count_after", 32'(bus.o_count), 32'd1);
    drive(1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
    check_eq("nobyp_drained", 32'(bus.o_count), 32'd0);
`endif

    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exe_result_fifo.md
Name: exe_result_fifo

Overview:
- Downstream stage of the execution unit. Captures the registered result/status pair the unit produces each cycle into a DEPTH-entry buffer.
- Presents entries in order to a consumer over a valid/ready interface.
- Keeps an error-entry counter and a sticky overflow flag for debug readout.
- The execution unit has no backpressure, so this block never stalls its input: it drops on full and flags the drop.

Parameters:
ARG_BYTES, 4, width in bits of result data; must match the execution unit's ARG_BYTES
DEPTH, 8, number of buffer entries; power of two, >= 2
ERR_CNT_W, 8, width of the saturating error-entry counter

Ports:
i_clk  input  1  clock; all state updates on posedge
i_rsn  input  1  synchronous, active-high reset
i_valid  input  1  i_result/i_status hold a new execution result this cycle
i_result  input  ARG_BYTES  execution result
i_status  input  4  execution status; bit 3 = error, bit 2 / bit 0 = result flags
o_ready  output  1  buffer not full (informational; upstream does not stall)
o_valid  output  1  head entry available
o_result  output  ARG_BYTES  head entry result; 0 when o_valid=0
o_status  output  4  head entry status; 0 when o_valid=0
i_ready  input  1  consumer accepts head when o_valid=1
o_count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
o_overflow  output  1  sticky: at least one push was dropped
o_err_cnt  output  ERR_CNT_W  accepted entries with i_status[3]=1, saturating

Behaviour:
- Reset: on a posedge with i_rsn=1:
  - rd_ptr, wr_ptr and count go to 0.
  - o_overflow and o_err_cnt go to 0.
  - Result: o_valid=0, o_result=0, o_status=0, o_ready=1.
  - Storage contents are don't-care.
  - Reset overrides any same-cycle push or pop. Reset mid-stream discards all entries.
- Push and pop conditions:
  - push_req = i_valid.
  - pop = o_valid & i_ready.
  - push_ok = push_req & (count<DEPTH | pop). A simultaneous pop frees the slot, so a push into a full buffer succeeds when a pop happens in the same cycle.
- Push: on push_ok, store {i_status,i_result} at wr_ptr; wr_ptr increments modulo DEPTH.
- Drop: push_req & !push_ok means the entry is discarded and o_overflow sets to 1 next cycle. o_overflow clears only on reset.
- Pop: rd_ptr increments modulo DEPTH.
- Count:
  - count increments on push_ok & !pop.
  - count decrements on pop & !push_ok.
  - count is unchanged when both or neither occur.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided by count, not by pointer compare.
- Outputs:
  - o_valid = (count!=0).
  - o_result/o_status are a combinational read of the entry at rd_ptr, gated to 0 when !o_valid.
  - o_ready = (count<DEPTH).
  - o_count = count.
- Latency (feature disabled): an entry pushed in cycle N is visible on o_valid in cycle N+1.
- Ordering: strict FIFO.
- Error counter: o_err_cnt increments on push_ok & i_status[3]. It saturates at all-ones and does not count dropped entries.
- The consumer may hold i_ready=1 continuously, giving one pop per cycle.
- No X propagation: outputs are fully defined after the first reset.

Optional Feature:
EXE_RES_BYPASS_EN
- Defined: when count==0 and i_valid=1, the input is forwarded in the same cycle:
  - o_valid=1, with o_result=i_result and o_status=i_status.
  - If i_ready=1 that cycle, the entry is consumed without being written; count and pointers are unchanged.
  - If i_ready=0, the entry is written as a normal push.
  - o_err_cnt still counts bypassed error entries.
- Not defined: no combinational path from i_* to o_*; latency is exactly 1 cycle.

Test Plan:
- Reset then idle:
  - Stimulus: i_rsn=1 for 2 cycles, then 0; i_valid=0.
  - Response: o_valid=0, o_result=0, o_status=0, o_count=0, o_ready=1, o_overflow=0, o_err_cnt=0.
- Order and latency:
  - Stimulus: push results 0x1,0x2,0x3 on consecutive cycles with i_ready=0, then i_ready=1.
  - Response: o_count reaches 3; o_result pops 0x1,0x2,0x3 on successive cycles; o_valid falls after the third pop; o_count=0.
- Full and drop:
  - Stimulus: DEPTH=8, 9 consecutive pushes with data 0..8, i_ready=0.
  - Response: o_ready=0 after the 8th push; data 8 dropped; o_overflow=1; draining yields 0..7.
- Full with simultaneous pop:
  - Stimulus: buffer full, i_valid=1 with data 0xA and i_ready=1 in the same cycle.
  - Response: head popped; 0xA accepted; o_count stays 8; o_overflow stays 0; 0xA emerges last.
- Wrap and error count:
  - Stimulus: 20 pushes interleaved with pops, every 4th push with i_status=4'b1000.
  - Response: data order preserved across pointer wrap; o_err_cnt=5.
- Reset mid-stream:
  - Stimulus: 5 entries held; i_rsn=1 on the same cycle as a push and a pop.
  - Response: next cycle o_count=0, o_valid=0, o_err_cnt=0.
  - Bypass check (EXE_RES_BYPASS_EN defined): empty buffer, i_valid=1 with 0x7 and i_ready=1 gives o_valid=1 and o_result=0x7 in the same cycle, with o_count still 0.
